// File: rtl/dmem_if.sv
// Data-memory port bundle: chip/write enables, address and write data from the
// access controller, read data and completion back from the memory.
interface dmem_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_ceb;
  logic          mem_web;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport master (
    output mem_ceb, mem_web, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_ceb, mem_web, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns EX-stage load/store strobes into a single
// variable-latency memory transaction, stalls the pipeline while it is in
// flight, returns load data and reports misaligned, conflicting or timed-out
// accesses as one-cycle exception pulses.
module dmem_access_ctrl #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          DmemREB,
  input  logic          DmemWEB,
  input  logic [AW-1:0] Addr,
  input  logic [DW-1:0] WData,
  input  logic          flush,
  dmem_if.master        mem,
  output logic          stall,
  output logic [DW-1:0] LoadData,
  output logic          load_valid,
  output logic          exc,
  output logic [1:0]    exc_code
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  state_t          state_r,      state_s;
  logic            mem_ceb_r,    mem_ceb_s;
  logic            mem_web_r,    mem_web_s;
  logic [AW-1:0]   mem_addr_r,   mem_addr_s;
  logic [DW-1:0]   mem_wdata_r,  mem_wdata_s;
  logic [DW-1:0]   load_data_r,  load_data_s;
  logic            load_valid_r, load_valid_s;
  logic            exc_r,        exc_s;
  logic [1:0]      exc_code_r,   exc_code_s;
  logic [CW-1:0]   cnt_r,        cnt_s;
  logic            req_s;
  logic            stall_s;

  // A request only exists while idle and not squashed by flush.
  assign req_s = (~DmemREB | ~DmemWEB) & ~flush;

  // Next-state, next-register and combinational stall decode.
  always_comb begin
    state_s      = state_r;
    mem_ceb_s    = mem_ceb_r;
    mem_web_s    = mem_web_r;
    mem_addr_s   = mem_addr_r;
    mem_wdata_s  = mem_wdata_r;
    load_data_s  = load_data_r;
    load_valid_s = 1'b0;
    exc_s        = 1'b0;
    exc_code_s   = exc_code_r;
    cnt_s        = cnt_r;
    stall_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        stall_s = req_s;
        if (req_s && !DmemREB && !DmemWEB) begin
          state_s    = ST_ERR;
          exc_s      = 1'b1;
          exc_code_s = 2'b10;
        end else if (req_s && (Addr[1:0] != 2'b00)) begin
          state_s    = ST_ERR;
          exc_s      = 1'b1;
          exc_code_s = 2'b01;
        end else if (req_s) begin
          state_s     = ST_ACCESS;
          mem_ceb_s   = 1'b0;
          mem_web_s   = DmemWEB;
          mem_addr_s  = Addr;
          mem_wdata_s = WData;
          cnt_s       = {CW{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // Pipeline inputs are deliberately ignored: the transaction runs to
        // completion or timeout once started.
        stall_s = 1'b1;
        if (mem.mem_ready) begin
          state_s      = ST_DONE;
          mem_ceb_s    = 1'b1;
          mem_web_s    = 1'b1;
          // mem_web_r still holds the direction of the finishing access.
          load_valid_s = mem_web_r;
          if (mem_web_r) begin
            load_data_s = mem.mem_rdata;
          end else begin
            load_data_s = load_data_r;
          end
        end else if (cnt_r == CNT_LAST) begin
          state_s    = ST_ERR;
          mem_ceb_s  = 1'b1;
          mem_web_s  = 1'b1;
          exc_s      = 1'b1;
          exc_code_s = 2'b11;
        end else begin
          cnt_s = cnt_r + CW'(1'b1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      ST_ERR: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s   = ST_IDLE;
        mem_ceb_s = 1'b1;
        mem_web_s = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset drops the memory enables immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      mem_ceb_r    <= 1'b1;
      mem_web_r    <= 1'b1;
      mem_addr_r   <= {AW{1'b0}};
      mem_wdata_r  <= {DW{1'b0}};
      load_data_r  <= {DW{1'b0}};
      load_valid_r <= 1'b0;
      exc_r        <= 1'b0;
      exc_code_r   <= 2'b00;
      cnt_r        <= {CW{1'b0}};
    end else begin
      state_r      <= state_s;
      mem_ceb_r    <= mem_ceb_s;
      mem_web_r    <= mem_web_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      load_data_r  <= load_data_s;
      load_valid_r <= load_valid_s;
      exc_r        <= exc_s;
      exc_code_r   <= exc_code_s;
      cnt_r        <= cnt_s;
    end
  end

  assign mem.mem_ceb   = mem_ceb_r;
  assign mem.mem_web   = mem_web_r;
  assign mem.mem_addr  = mem_addr_r;
  assign mem.mem_wdata = mem_wdata_r;
  assign stall         = stall_s;
  assign LoadData      = load_data_r;
  assign load_valid    = load_valid_r;
  assign exc           = exc_r;
  assign exc_code      = exc_code_r;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: the bench plays the memory, drives one
// access at a time over a fixed window and checks counted cycles and pulses
// against hand-computed values.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        DmemREB;
  logic        DmemWEB;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        flush;
  logic        stall;
  logic [31:0] LoadData;
  logic        load_valid;
  logic        exc;
  logic [1:0]  exc_code;

  dmem_if #(.AW(32), .DW(32)) mif ();

  dmem_access_ctrl #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .DmemREB    (DmemREB),
    .DmemWEB    (DmemWEB),
    .Addr       (Addr),
    .WData      (WData),
    .flush      (flush),
    .mem        (mif),
    .stall      (stall),
    .LoadData   (LoadData),
    .load_valid (load_valid),
    .exc        (exc),
    .exc_code   (exc_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Results of the most recent access window.
  int          r_stall, r_ceb, r_lv, r_exc;
  logic [31:0] r_ld, r_addr, r_wdata;
  logic [1:0]  r_code;
  logic        r_web, r_stable;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request in the current IDLE cycle, then a 24-cycle window in which
  // the bench acts as memory: ready is raised on ACCESS cycle ready_at
  // (1-based, 0 = never). Called at posedge+1.
  task automatic do_access(input logic reb, input logic web, input logic fl,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ready_at, input logic [31:0] rdata);
    int acc;
    acc = 0;
    r_stall = 0; r_ceb = 0; r_lv = 0; r_exc = 0;
    r_ld = 32'h0; r_code = 2'b00; r_web = 1'b1; r_stable = 1'b1;
    r_addr = 32'h0; r_wdata = 32'h0;
    for (int c = 0; c < 24; c++) begin
      if (c == 0) begin
        DmemREB = reb; DmemWEB = web; flush = fl; Addr = addr; WData = wdata;
      end else begin
        DmemREB = 1'b1; DmemWEB = 1'b1; flush = 1'b0;
        Addr = 32'hFFFF_FFFF; WData = 32'hA5A5_A5A5;
      end
      @(negedge clk);
      if (stall) r_stall++;
      if (load_valid) begin r_lv++; r_ld = LoadData; end
      if (exc) begin r_exc++; r_code = exc_code; end
      if (!mif.mem_ceb) begin
        r_ceb++;
        acc++;
        if (acc == 1) begin
          r_web = mif.mem_web; r_addr = mif.mem_addr; r_wdata = mif.mem_wdata;
        end else if (mif.mem_web !== r_web || mif.mem_addr !== r_addr ||
                     mif.mem_wdata !== r_wdata) begin
          r_stable = 1'b0;
        end
        if (acc == ready_at) begin
          mif.mem_ready = 1'b1; mif.mem_rdata = rdata;
        end
      end
      @(posedge clk);
      #1;
      mif.mem_ready = 1'b0;
      mif.mem_rdata = 32'h5555_AAAA;
    end
  endtask

  initial begin
    rst_n = 1'b0; DmemREB = 1'b1; DmemWEB = 1'b1; flush = 1'b0;
    Addr = 32'h0; WData = 32'h0;
    mif.mem_ready = 1'b0; mif.mem_rdata = 32'h5555_AAAA;

    // Reset values
    #12;
    chk("rst_ceb",   {31'd0, mif.mem_ceb}, 32'd1);
    chk("rst_web",   {31'd0, mif.mem_web}, 32'd1);
    chk("rst_addr",  mif.mem_addr, 32'h0);
    chk("rst_wdata", mif.mem_wdata, 32'h0);
    chk("rst_ld",    LoadData, 32'h0);
    chk("rst_lv",    {31'd0, load_valid}, 32'd0);
    chk("rst_exc",   {31'd0, exc}, 32'd0);
    chk("rst_code",  {30'd0, exc_code}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Load, zero wait
    do_access(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF);
    chk("ld0_stall", r_stall, 32'd2);
    chk("ld0_ceb",   r_ceb, 32'd1);
    chk("ld0_web",   {31'd0, r_web}, 32'd1);
    chk("ld0_addr",  r_addr, 32'h10);
    chk("ld0_lv",    r_lv, 32'd1);
    chk("ld0_data",  r_ld, 32'hDEAD_BEEF);
    chk("ld0_exc",   r_exc, 32'd0);

    // Store, ready on 4th ACCESS cycle
    do_access(1'b1, 1'b0, 1'b0, 32'h0000_0024, 32'h1234_5678, 4, 32'hBAD0_BAD0);
    chk("st3_stall",  r_stall, 32'd5);
    chk("st3_ceb",    r_ceb, 32'd4);
    chk("st3_web",    {31'd0, r_web}, 32'd0);
    chk("st3_addr",   r_addr, 32'h24);
    chk("st3_wdata",  r_wdata, 32'h1234_5678);
    chk("st3_stable", {31'd0, r_stable}, 32'd1);
    chk("st3_lv",     r_lv, 32'd0);
    chk("st3_exc",    r_exc, 32'd0);
    chk("st3_ldkeep", LoadData, 32'hDEAD_BEEF);

    // Misaligned load
    do_access(1'b0, 1'b1, 1'b0, 32'h0000_0013, 32'h0, 1, 32'h0);
    chk("mis_stall", r_stall, 32'd1);
    chk("mis_ceb",   r_ceb, 32'd0);
    chk("mis_exc",   r_exc, 32'd1);
    chk("mis_code",  {30'd0, r_code}, 32'd1);

    // Conflict (also misaligned: conflict takes priority)
    do_access(1'b0, 1'b0, 1'b0, 32'h0000_0041, 32'h0, 1, 32'h0);
    chk("cfl_stall", r_stall, 32'd1);
    chk("cfl_ceb",   r_ceb, 32'd0);
    chk("cfl_exc",   r_exc, 32'd1);
    chk("cfl_code",  {30'd0, r_code}, 32'd2);

    // Flushed load
    do_access(1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h0, 1, 32'h0);
    chk("fl_stall", r_stall, 32'd0);
    chk("fl_ceb",   r_ceb, 32'd0);
    chk("fl_exc",   r_exc, 32'd0);
    chk("fl_lv",    r_lv, 32'd0);
    chk("fl_code",  {30'd0, exc_code}, 32'd2);

    // Timeout
    do_access(1'b0, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 0, 32'h0);
    chk("to_ceb",   r_ceb, 32'd16);
    chk("to_stall", r_stall, 32'd17);
    chk("to_exc",   r_exc, 32'd1);
    chk("to_code",  {30'd0, r_code}, 32'd3);
    chk("to_lv",    r_lv, 32'd0);

    // Normal load after timeout, one wait cycle
    do_access(1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 2, 32'hCAFE_F00D);
    chk("ld1_stall", r_stall, 32'd3);
    chk("ld1_ceb",   r_ceb, 32'd2);
    chk("ld1_lv",    r_lv, 32'd1);
    chk("ld1_data",  r_ld, 32'hCAFE_F00D);

    // Asynchronous reset in the middle of ACCESS
    DmemREB = 1'b0; Addr = 32'h0000_0030;
    @(posedge clk); #1;
    DmemREB = 1'b1;
    @(negedge clk);
    chk("ar_pre_ceb", {31'd0, mif.mem_ceb}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ceb",   {31'd0, mif.mem_ceb}, 32'd1);
    chk("ar_web",   {31'd0, mif.mem_web}, 32'd1);
    chk("ar_stall", {31'd0, stall}, 32'd0);
    chk("ar_addr",  mif.mem_addr, 32'h0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_idle_ceb",   {31'd0, mif.mem_ceb}, 32'd1);
    chk("ar_idle_stall", {31'd0, stall}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences every data-memory access requested by the EX stage (load/store) onto a variable-latency data memory port.
- Consumes the active-low DmemREB/DmemWEB strobes, effective address and store data produced by ID/EX control and ALU.
- Drives the memory handshake, stalls the pipeline until the access completes, returns load data to MEM/WB, and flags misaligned, conflicting and timed-out accesses.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, max cycles in ACCESS waiting for mem_ready before error (>=2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- DmemREB  in  1  read request from EX, active low
- DmemWEB  in  1  write request from EX, active low
- Addr  in  AW  effective address (ALU result)
- WData  in  DW  store data
- flush  in  1  squash the current EX instruction
- mem_ceb  out  1  memory chip enable, active low
- mem_web  out  1  memory write enable, active low (valid only when mem_ceb=0)
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completion, sampled while mem_ceb=0
- stall  out  1  freeze PC and IF/ID/EX registers
- LoadData  out  DW  captured load data
- load_valid  out  1  LoadData valid, one-cycle pulse
- exc  out  1  access exception, one-cycle pulse
- exc_code  out  2  01 misaligned, 10 REB/WEB both low, 11 timeout

Behaviour:
- Clocking: clk only. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, mem_ceb=1, mem_web=1, mem_addr=0, mem_wdata=0, LoadData=0, load_valid=0, exc=0, exc_code=00, wait counter=0. stall is combinational and evaluates to 0 in IDLE with no request.
- States: IDLE, ACCESS, DONE, ERR.
- Request (IDLE only): req = (~DmemREB | ~DmemWEB) & ~flush.
- IDLE:
  - stall = req (combinational, same cycle).
  - If req and both strobes low: go to ERR, exc_code=10.
  - Else if req and Addr[1:0]!=0: go to ERR, exc_code=01.
  - Else if req: register mem_addr=Addr, mem_wdata=WData, mem_web=DmemWEB, mem_ceb=0, counter=0, and go to ACCESS.
  - flush=1 suppresses any request; no memory activity, stall=0.
- ACCESS:
  - stall=1. mem_ceb, mem_web, mem_addr and mem_wdata are held stable.
  - Inputs DmemREB, DmemWEB, Addr, WData and flush are ignored; a started transaction is never aborted.
  - If mem_ready: mem_ceb=1, mem_web=1. For a read, LoadData=mem_rdata. Go to DONE.
  - Else if counter==TIMEOUT-1: mem_ceb=1, mem_web=1, exc_code=11, go to ERR.
  - Else counter+1.
- DONE (1 cycle):
  - stall=0, so the pipeline advances at the end of this cycle.
  - load_valid=1 for reads only. Go to IDLE.
  - Request inputs are ignored; they still belong to the retiring instruction.
- ERR (1 cycle):
  - stall=0, exc=1, exc_code holds its value. LoadData is unchanged and no memory access is made. Go to IDLE.
- Latency:
  - Minimum access: request cycle (IDLE), one ACCESS cycle (ready=1 on first ACCESS cycle), then DONE. This gives 2 stall cycles.
  - A ready arriving after k waiting ACCESS cycles gives k+2 stall cycles.
- Outputs:
  - load_valid and exc are registered and high only in DONE and ERR respectively.
  - exc_code is registered and holds its last value otherwise.
- Asynchronous reset mid-ACCESS: mem_ceb and mem_web go to 1 immediately and the state returns to IDLE. The memory is responsible for tolerating the dropped enable.
- Back-to-back: a new request is accepted only in the IDLE cycle following DONE or ERR. The maximum rate is one access per 3 cycles.

Test Plan:
- Reset to idle: assert rst_n=0 mid-ACCESS -> mem_ceb=1, stall=0, state IDLE with no clock edge.
- Load with 0 wait: DmemREB=0, Addr=0x0000_0010, ready on first ACCESS cycle with mem_rdata=0xDEADBEEF -> mem_ceb=0 and mem_web=1 for 1 cycle, stall high for 2 cycles, load_valid=1 with LoadData=0xDEADBEEF in DONE.
- Store with 3-cycle wait: DmemWEB=0, Addr=0x24, WData=0x1234_5678, ready on 4th ACCESS cycle -> mem_web=0 and mem_addr/mem_wdata stable for 4 cycles, stall high 5 cycles, load_valid=0, exc=0.
- Misaligned access: DmemREB=0, Addr=0x13 -> mem_ceb stays 1, one exc pulse with exc_code=01, stall high 1 cycle.
- Conflict and flush:
  - REB=WEB=0 -> exc_code=10, no memory access.
  - REB=0 with flush=1 -> no stall, no access, no exc.
- Timeout: TIMEOUT=16, mem_ready held 0 -> mem_ceb=0 for exactly 16 cycles, then ERR with exc_code=11, then IDLE accepts the next load normally.
